// File: rtl/aes_pkg.sv
// Shared AES constants and encodings for the S-box scheduler.
// Holds FSM state and requester ID types.
package aes_pkg;

  localparam int STATE_W     = 128;
  localparam int WORD_W      = 32;
  localparam int BYTE_W      = 8;
  localparam int STATE_BYTES = 16;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_ST = 2'd1,
    RUN_KW = 2'd2
  } sched_state_t;

  typedef enum logic {
    REQ_ST = 1'b0,
    REQ_KW = 1'b1
  } req_id_t;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Computed as GF(2^8) inverse followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse as x^254 (maps 0 to 0), then affine transform
  always_comb begin
    logic [7:0] p;
    logic [7:0] r;
    p = din;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    dout = r
         ^ {r[6:0], r[7]}
         ^ {r[5:0], r[7:6]}
         ^ {r[4:0], r[7:5]}
         ^ {r[3:0], r[7:4]}
         ^ 8'h63;
  end

endmodule

// File: rtl/sbox_scheduler.sv
// Shares NUM_SBOX S-boxes between SubBytes and SubWord.
// Round-robin grant, chunked substitution, registered results.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_req_valid,
  output logic               st_req_ready,
  input  logic [STATE_W-1:0] st_in,
  output logic [STATE_W-1:0] st_out,
  output logic               st_done,
  input  logic               kw_req_valid,
  output logic               kw_req_ready,
  input  logic [WORD_W-1:0]  kw_in,
  output logic [WORD_W-1:0]  kw_out,
  output logic               kw_done,
  output logic               busy
);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 ||
        NUM_SBOX == 4)) begin : g_bad_param
    $error("NUM_SBOX must be 1, 2 or 4");
  end

  localparam int ST_CHUNKS = STATE_BYTES / NUM_SBOX;
  localparam int KW_CHUNKS = WORD_BYTES / NUM_SBOX;
  localparam logic [3:0] ST_LAST = 4'(ST_CHUNKS - 1);
  localparam logic [3:0] KW_LAST = 4'(KW_CHUNKS - 1);

  sched_state_t       state_q, state_d;
  req_id_t            last_q, last_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [STATE_W-1:0] merged;
  logic               st_fin, kw_fin;

  logic [3:0]        lane_idx [NUM_SBOX];
  logic [BYTE_W-1:0] sb_in    [NUM_SBOX];
  logic [BYTE_W-1:0] sb_out   [NUM_SBOX];

  assign busy = (state_q != IDLE);

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
    assign lane_idx[k] = 4'(int'(cnt_q) * NUM_SBOX + k);
    assign sb_in[k] = busy ?
      work_q[{lane_idx[k], 3'b000} +: BYTE_W] : '0;
    aes_sbox u_sbox (
      .din  (sb_in[k]),
      .dout (sb_out[k])
    );
  end

  // write the current chunk's substituted bytes back in place
  always_comb begin
    merged = work_q;
    for (int k = 0; k < NUM_SBOX; k++) begin
      merged[{lane_idx[k], 3'b000} +: BYTE_W] = sb_out[k];
    end
  end

  // arbitration, acceptance and chunk sequencing
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    st_req_ready = 1'b0;
    kw_req_ready = 1'b0;
    st_fin       = 1'b0;
    kw_fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        st_req_ready = st_req_valid &&
          (!kw_req_valid || last_q == REQ_KW);
        kw_req_ready = kw_req_valid &&
          (!st_req_valid || last_q == REQ_ST);
        if (st_req_ready) begin
          work_d  = st_in;
          cnt_d   = '0;
          last_d  = REQ_ST;
          state_d = RUN_ST;
        end else if (kw_req_ready) begin
          work_d  = {{(STATE_W-WORD_W){1'b0}}, kw_in};
          cnt_d   = '0;
          last_d  = REQ_KW;
          state_d = RUN_KW;
        end
      end
      RUN_ST: begin
        work_d = merged;
        if (cnt_q == ST_LAST) begin
          st_fin  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RUN_KW: begin
        work_d = merged;
        if (cnt_q == KW_LAST) begin
          kw_fin  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control and working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_ST;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // result registers and done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_out  <= '0;
      kw_out  <= '0;
      st_done <= 1'b0;
      kw_done <= 1'b0;
    end else begin
      st_done <= st_fin;
      kw_done <= kw_fin;
      if (st_fin) st_out <= merged;
      if (kw_fin) kw_out <= merged[WORD_W-1:0];
    end
  end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Scoreboard bench for sbox_scheduler.
// Instance a uses NUM_SBOX=4, instance b uses NUM_SBOX=1.
module tb_sbox_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  logic         v    [4];
  logic [127:0] din  [4];
  logic [127:0] pexp [4];
  logic         rdy  [4];
  logic         done [4];
  logic [127:0] dout [4];

  logic [127:0] a_st_out, b_st_out;
  logic [31:0]  a_kw_out, b_kw_out;
  logic         a_busy, b_busy;

  sbox_scheduler #(.NUM_SBOX(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .st_req_valid (v[0]),
    .st_req_ready (rdy[0]),
    .st_in        (din[0]),
    .st_out       (a_st_out),
    .st_done      (done[0]),
    .kw_req_valid (v[1]),
    .kw_req_ready (rdy[1]),
    .kw_in        (din[1][31:0]),
    .kw_out       (a_kw_out),
    .kw_done      (done[1]),
    .busy         (a_busy)
  );

  sbox_scheduler #(.NUM_SBOX(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .st_req_valid (v[2]),
    .st_req_ready (rdy[2]),
    .st_in        (din[2]),
    .st_out       (b_st_out),
    .st_done      (done[2]),
    .kw_req_valid (v[3]),
    .kw_req_ready (rdy[3]),
    .kw_in        (din[3][31:0]),
    .kw_out       (b_kw_out),
    .kw_done      (done[3]),
    .busy         (b_busy)
  );

  assign dout[0] = a_st_out;
  assign dout[1] = {96'b0, a_kw_out};
  assign dout[2] = b_st_out;
  assign dout[3] = {96'b0, b_kw_out};

  function automatic int lat(input int c);
    case (c)
      0: return 4;
      1: return 1;
      2: return 16;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string n,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic push(input int c, input exp_t e);
    case (c)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int pending();
    return q0.size() + q1.size() + q2.size() + q3.size();
  endfunction

  task automatic mon(input int c);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (c)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      default:
         if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      tests++;
      fails++;
      $display("FAIL unexpected_done ch%0d: got done at cycle %0d expected none",
               c, cyc);
    end else begin
      check($sformatf("data_ch%0d", c), dout[c], e.d);
      check($sformatf("latency_ch%0d", c), 128'(cyc), 128'(e.c));
    end
  endtask

  // monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (done[c] === 1'b1) mon(c);
    end
  end

  task automatic offer(input int c,
                       input logic [127:0] d,
                       input logic [127:0] e);
    din[c]  = d;
    pexp[c] = e;
    v[c]    = 1'b1;
  endtask

  task automatic wait_accept();
    bit acc [4];
    bit any;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        acc[c] = 1'b0;
        if (v[c] && rdy[c]) begin
          push(c, '{pexp[c], cyc + 1 + lat(c)});
          acc[c] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      any = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (acc[c]) v[c] = 1'b0;
        any = any | v[c];
      end
      if (!any) return;
    end
    tests++;
    fails++;
    $display("FAIL accept_timeout: got no ready expected ready");
    for (int c = 0; c < 4; c++) v[c] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50; n++) begin
      if (pending() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", 128'(pending()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] ALL01 = {16{8'h01}};
  localparam logic [127:0] ALL7C = {16{8'h7C}};

  initial begin
    for (int c = 0; c < 4; c++) begin
      v[c]    = 1'b0;
      din[c]  = '0;
      pexp[c] = '0;
    end
    #2;
    check("rst_st_out", a_st_out, 128'd0);
    check("rst_kw_out", 128'(a_kw_out), 128'd0);
    check("rst_st_done", 128'(done[0]), 128'd0);
    check("rst_kw_done", 128'(done[1]), 128'd0);
    check("rst_busy", 128'(a_busy), 128'd0);
    check("rst_busy_b", 128'(b_busy), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    offer(0, 128'd0, ALL63);
    #1;
    check("st_ready_same_cycle", 128'(rdy[0]), 128'd1);
    wait_accept();
    check("busy_running", 128'(a_busy), 128'd1);
    drain();
    check("busy_idle", 128'(a_busy), 128'd0);

    offer(1, 128'hDFCC_FF19, 128'h9E4B_16D4);
    wait_accept();
    drain();
    offer(1, 128'h4EA3_5623, 128'h2F0A_B126);
    wait_accept();
    drain();

    #3 rst = 1'b1;
    #1;
    check("async_rst_st_out", a_st_out, 128'd0);
    check("async_rst_kw_out", 128'(a_kw_out), 128'd0);
    check("async_rst_busy", 128'(a_busy), 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    offer(0, ALL01, ALL7C);
    offer(1, 128'hDFCC_FF19, 128'h9E4B_16D4);
    #1;
    check("tie1_kw_ready", 128'(rdy[1]), 128'd1);
    check("tie1_st_ready", 128'(rdy[0]), 128'd0);
    wait_accept();
    drain();
    check("kw_hold_1", 128'(a_kw_out), 128'h9E4B_16D4);

    offer(0, 128'd0, ALL63);
    offer(1, 128'h4EA3_5623, 128'h2F0A_B126);
    #1;
    check("tie2_kw_ready", 128'(rdy[1]), 128'd1);
    check("tie2_st_ready", 128'(rdy[0]), 128'd0);
    wait_accept();
    drain();
    check("kw_hold_2", 128'(a_kw_out), 128'h2F0A_B126);
    check("st_hold_2", a_st_out, ALL63);

    offer(0, 128'd0, ALL63);
    wait_accept();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    q0.delete();
    #1;
    check("abort_st_out", a_st_out, 128'd0);
    check("abort_st_done", 128'(done[0]), 128'd0);
    check("abort_busy", 128'(a_busy), 128'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_st_out_later", a_st_out, 128'd0);
    offer(0, ALL01, ALL7C);
    wait_accept();
    drain();

    offer(2, ALL01, ALL7C);
    wait_accept();
    drain();
    offer(3, 128'h0000_0053, 128'h6363_63ED);
    wait_accept();
    drain();
    check("b_st_hold", b_st_out, ALL7C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sbox_scheduler.md
Name: sbox_scheduler

Overview:
- Time-multiplexes a small pool of S_box instances between two requesters: the round datapath (SubBytes on the 128-bit state) and key expansion (SubWord on a 32-bit word).
- Each accepted job is substituted NUM_SBOX bytes per cycle.
- Arbitrates requests round-robin, sequences the byte chunks and returns registered results with a one-cycle done pulse.
- Sits between the AES round controller / key expansion unit and the S-box pool.

Parameters:
- NUM_SBOX, 4, number of S_box instances; legal values 1, 2, 4. Other values are illegal (elaboration error).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- st_req_valid  in  1  state substitution request
- st_req_ready  out  1  state request accepted this cycle when valid&ready
- st_in  in  128  state to substitute; byte i = st_in[8i+7:8i]
- st_out  out  128  substituted state, registered
- st_done  out  1  one-cycle pulse: st_out valid
- kw_req_valid  in  1  key-word substitution request
- kw_req_ready  out  1  key request accepted when valid&ready
- kw_in  in  32  word to substitute; byte i = kw_in[8i+7:8i]
- kw_out  out  32  substituted word, registered
- kw_done  out  1  one-cycle pulse: kw_out valid
- busy  out  1  high while a job is in progress (RUN_ST or RUN_KW)

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: FSM=IDLE, st_out=0, kw_out=0, st_done=0, kw_done=0, busy=0, chunk counter=0, round-robin pointer=STATE (key wins the first tie).
- FSM states: IDLE, RUN_ST, RUN_KW.
- Ready rules: ready is asserted only in IDLE, and only for the requester selected by arbitration. Ready may depend combinationally on the valids.
- Arbitration in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not served last. The pointer updates on each acceptance.
  - No preemption: an in-flight job always completes.
- Acceptance (valid&ready at edge E0):
  - Input is captured into the working register; the requester may change its input afterwards.
  - Counter is cleared; FSM goes to RUN_ST or RUN_KW.
  - A dropped valid before acceptance has no effect.
- Chunk processing in RUN: each cycle, bytes [cnt*NUM_SBOX .. cnt*NUM_SBOX+NUM_SBOX-1] of the working register pass through the pool and are written back in place. cnt then increments.
- Chunk counts: C = 16/NUM_SBOX for state, C = 4/NUM_SBOX for key word. Counter width is sized for the maximum of 16.
- Completion:
  - On the edge that writes chunk C-1, the full result is loaded into st_out or kw_out, the matching done is set for exactly one cycle, and FSM returns to IDLE.
  - Done rises C cycles after E0: state is 4 cycles and key is 1 cycle at the default NUM_SBOX=4.
  - A new job may be accepted in the same cycle done is high.
- Output hold: st_out and kw_out hold their value until that requester's next completion and are unaffected by the other requester's jobs.
- Pool inputs: S_box inputs not in use are driven 0.
- busy = (FSM != IDLE).
- Reset mid-operation: the job is aborted, no done pulse, all outputs take their reset values, and the pointer is reset.

Decomposition:
- Package aes_pkg holds:
  - Constants: STATE_W=128, WORD_W=32, BYTE_W=8, STATE_BYTES=16, WORD_BYTES=4.
  - The FSM state encoding.
  - Requester ID encoding (REQ_ST=0, REQ_KW=1).
- Sub-modules: the existing combinational S_box, instantiated NUM_SBOX times in a generate loop. No new sub-module is needed; lane select and write-back stay inline.

Test Plan:
1. Reset: assert rst mid-cycle (asynchronous) -> all outputs 0 immediately, busy=0. Release, raise st_req_valid -> st_req_ready=1 in the same cycle.
2. State job, NUM_SBOX=4: st_in = 128'h0 -> busy for 4 cycles, st_done pulses once 4 cycles after acceptance, st_out = 128'h6363...63 (16 bytes of 63).
3. Key job: kw_in = 32'hDFCC_FF19 -> kw_done 1 cycle after acceptance, kw_out = 32'h9E4B_16D4. Then kw_in = 32'h4EA3_5623 -> kw_out = 32'h2F0A_B126.
4. Contention: both valid after reset -> key is granted first (kw_done after 1 cycle). State is then accepted in the same cycle kw_done is high; st_done follows 4 cycles later. A second simultaneous pair after that is granted to key again (the state job was served last). kw_out is unchanged by the state job.
5. Reset abort: accept st_in = 128'h0, assert rst after 2 RUN cycles -> st_done never pulses, st_out stays 0. A subsequent job completes normally.
6. NUM_SBOX=1: st_in with byte i = 8'h01 -> 16-cycle latency, all bytes = 7C. Key word 32'h0000_0053 -> 4-cycle latency, kw_out = 32'h6363_63ED.
